// File: rtl/fixed_point_abs_peak_acc.sv
// fixed_point_abs_peak_acc: per-frame L1 sum, peak and peak index of magnitudes; FIXED_POINT_ABS_PEAK_ACC_MEAN_EN adds MEAN_OUT
module fixed_point_abs_peak_acc #(
    parameter int WIDTH = 8,
    parameter int FRAC_BITS = 3,
    parameter int FRAME_LEN = 16,
    parameter int CNT_WIDTH = $clog2(FRAME_LEN + 1),
    parameter int ACC_WIDTH = WIDTH + $clog2(FRAME_LEN)
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [WIDTH-1:0]     VALUE_IN,
    input  logic                 VALID_IN,
    input  logic                 FLUSH_IN,
    output logic [ACC_WIDTH-1:0] SUM_OUT,
    output logic [WIDTH-1:0]     PEAK_OUT,
    output logic [CNT_WIDTH-1:0] PEAK_IDX_OUT,
    output logic [CNT_WIDTH-1:0] COUNT_OUT,
    output logic                 VALID_OUT,
    output logic                 BUSY_OUT,
    output logic                 ERROR_OUT
`ifdef FIXED_POINT_ABS_PEAK_ACC_MEAN_EN
    ,
    output logic [WIDTH-1:0]     MEAN_OUT
`endif
);
    typedef enum logic {IDLE, ACCUM} state_t;
    state_t state;
    logic signed [ACC_WIDTH-1:0] acc, acc_n;
    logic [WIDTH-1:0] peak, peak_n, v;
    logic [CNT_WIDTH-1:0] idx, idx_n, cnt, cnt_n;
    logic neg, upd, close;
    if (FRAME_LEN < 2) begin : g_len_chk
        $error("FRAME_LEN must be at least 2");
    end
    if (FRAC_BITS >= WIDTH) begin : g_frac_chk
        $error("FRAC_BITS must be below WIDTH");
    end
`ifdef FIXED_POINT_ABS_PEAK_ACC_MEAN_EN
    localparam int SH = $clog2(FRAME_LEN);
    if ((FRAME_LEN & (FRAME_LEN - 1)) != 0) begin : g_pow2_chk
        $error("FRAME_LEN must be a power of two when MEAN_OUT is enabled");
    end
`endif
    assign BUSY_OUT = state == ACCUM;
    always_comb begin
        neg = VALID_IN && VALUE_IN[WIDTH-1];
        v = VALUE_IN[WIDTH-1] ? '0 : VALUE_IN;
        upd = VALID_IN && (cnt == '0 || v > peak);
        acc_n = acc + (VALID_IN ? {{(ACC_WIDTH-WIDTH){v[WIDTH-1]}}, v} : '0);
        peak_n = upd ? v : peak;
        idx_n = upd ? cnt : idx;
        cnt_n = cnt + CNT_WIDTH'(VALID_IN);
        close = FLUSH_IN || (VALID_IN && cnt_n == CNT_WIDTH'(FRAME_LEN));
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            acc <= '0;
            peak <= '0;
            idx <= '0;
            cnt <= '0;
            SUM_OUT <= '0;
            PEAK_OUT <= '0;
            PEAK_IDX_OUT <= '0;
            COUNT_OUT <= '0;
            VALID_OUT <= 1'b0;
            ERROR_OUT <= 1'b0;
`ifdef FIXED_POINT_ABS_PEAK_ACC_MEAN_EN
            MEAN_OUT <= '0;
`endif
        end else begin
            VALID_OUT <= close;
            if (neg) ERROR_OUT <= 1'b1;
            if (close) begin
                SUM_OUT <= acc_n;
                PEAK_OUT <= peak_n;
                PEAK_IDX_OUT <= idx_n;
                COUNT_OUT <= cnt_n;
`ifdef FIXED_POINT_ABS_PEAK_ACC_MEAN_EN
                MEAN_OUT <= WIDTH'(acc_n >>> SH);
`endif
                acc <= '0;
                peak <= '0;
                idx <= '0;
                cnt <= '0;
                state <= IDLE;
            end else begin
                acc <= acc_n;
                peak <= peak_n;
                idx <= idx_n;
                cnt <= cnt_n;
                state <= cnt_n != '0 ? ACCUM : IDLE;
            end
        end
    end
endmodule

// File: tb/tb_fixed_point_abs_peak_acc.sv
// tb_fixed_point_abs_peak_acc: queue-based frame model checked every cycle plus literal spot checks
module tb_fixed_point_abs_peak_acc;
    localparam int W = 8, FL = 4, CW = 3, AW = 10;
    logic CLK = 0, RST = 1, VALID_IN = 0, FLUSH_IN = 0;
    logic [W-1:0] VALUE_IN = '0;
    logic [AW-1:0] SUM_OUT;
    logic [W-1:0] PEAK_OUT;
    logic [CW-1:0] PEAK_IDX_OUT, COUNT_OUT;
    logic VALID_OUT, BUSY_OUT, ERROR_OUT;
`ifdef FIXED_POINT_ABS_PEAK_ACC_MEAN_EN
    logic [W-1:0] MEAN_OUT;
`endif
    int total = 0, bad = 0;
    fixed_point_abs_peak_acc #(.WIDTH(W), .FRAC_BITS(3), .FRAME_LEN(FL)) dut (
        .CLK(CLK), .RST(RST), .VALUE_IN(VALUE_IN), .VALID_IN(VALID_IN), .FLUSH_IN(FLUSH_IN),
        .SUM_OUT(SUM_OUT), .PEAK_OUT(PEAK_OUT), .PEAK_IDX_OUT(PEAK_IDX_OUT), .COUNT_OUT(COUNT_OUT),
        .VALID_OUT(VALID_OUT), .BUSY_OUT(BUSY_OUT), .ERROR_OUT(ERROR_OUT)
`ifdef FIXED_POINT_ABS_PEAK_ACC_MEAN_EN
        , .MEAN_OUT(MEAN_OUT)
`endif
    );
    always #5 CLK = ~CLK;
    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask
    // Reference: collect the frame's samples, derive the record when the frame closes
    int q[$];
    int e_sum = 0, e_peak = 0, e_idx = 0, e_cnt = 0, e_mean = 0;
    bit e_valid = 0, e_busy = 0, e_err = 0, started = 0;
    always @(posedge CLK) begin
        if (RST) begin
            q.delete();
            {e_sum, e_peak, e_idx, e_cnt, e_mean} = '0;
            {e_valid, e_busy, e_err} = '0;
            started = 1;
        end else begin
            e_valid = 0;
            if (VALID_IN) begin
                if (VALUE_IN[W-1]) e_err = 1;
                q.push_back(VALUE_IN[W-1] ? 0 : int'(VALUE_IN));
            end
            if (FLUSH_IN || (VALID_IN && q.size() == FL)) begin
                e_sum = 0; e_peak = 0; e_idx = 0;
                foreach (q[i]) begin
                    e_sum += q[i];
                    if (i == 0 || q[i] > e_peak) begin
                        e_peak = q[i];
                        e_idx = i;
                    end
                end
                e_cnt = q.size();
                e_mean = e_sum / FL;
                e_valid = 1;
                q.delete();
            end
            e_busy = q.size() > 0;
        end
    end
    always @(negedge CLK) begin
        if (started) begin
            chk("valid", VALID_OUT, e_valid);
            chk("busy", BUSY_OUT, e_busy);
            chk("error", ERROR_OUT, e_err);
            chk("sum", SUM_OUT, e_sum);
            chk("peak", PEAK_OUT, e_peak);
            chk("peak_idx", PEAK_IDX_OUT, e_idx);
            chk("count", COUNT_OUT, e_cnt);
`ifdef FIXED_POINT_ABS_PEAK_ACC_MEAN_EN
            chk("mean", MEAN_OUT, e_mean);
`endif
        end
    end
    task automatic cyc(input logic [W-1:0] v, input logic vi, input logic fl);
        VALUE_IN = v; VALID_IN = vi; FLUSH_IN = fl;
        @(posedge CLK);
        #1;
        VALID_IN = 0; FLUSH_IN = 0; VALUE_IN = '0;
    endtask
    task automatic rec(input string tag, input int s, input int p, input int ix, input int c);
        chk({tag, "_valid"}, VALID_OUT, 1);
        chk({tag, "_sum"}, SUM_OUT, s);
        chk({tag, "_peak"}, PEAK_OUT, p);
        chk({tag, "_idx"}, PEAK_IDX_OUT, ix);
        chk({tag, "_cnt"}, COUNT_OUT, c);
        chk({tag, "_busy"}, BUSY_OUT, 0);
    endtask
    initial begin
        logic [W-1:0] ff[4] = '{8'h08, 8'h18, 8'h10, 8'h04};
        logic [W-1:0] ng[4] = '{8'h08, 8'hF8, 8'h08, 8'h08};
        logic [W-1:0] mn[4] = '{8'h08, 8'h10, 8'h18, 8'h20};
        RST = 1;
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        RST = 0;
        chk("rst_valid", VALID_OUT, 0);
        chk("rst_sum", SUM_OUT, 0);
        chk("rst_err", ERROR_OUT, 0);
        chk("rst_busy", BUSY_OUT, 0);
        for (int i = 0; i < 4; i++) cyc(ff[i], 1, 0);
        rec("full", 'h34, 'h18, 1, 4);
        cyc(0, 0, 0);
        chk("full_pulse_end", VALID_OUT, 0);
        for (int i = 0; i < 8; i++) begin
            cyc(8'h02, 1, 0);
            if (i == 3 || i == 7) rec("b2b", 'h08, 'h02, 0, 4);
            else chk("b2b_nopulse", VALID_OUT, 0);
        end
        cyc(0, 0, 0);
        cyc(8'h05, 1, 0);
        chk("busy_mid", BUSY_OUT, 1);
        cyc(8'h07, 1, 0);
        cyc(8'h07, 1, 1);
        rec("flush", 'h13, 'h07, 1, 3);
        cyc(0, 0, 1);
        rec("flush_idle", 0, 0, 0, 0);
        cyc(0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(ng[i], 1, 0);
        rec("neg", 'h18, 'h08, 0, 4);
        chk("neg_err", ERROR_OUT, 1);
        for (int i = 0; i < 4; i++) cyc(8'h03, 1, 0);
        rec("after_neg", 'h0C, 'h03, 0, 4);
        chk("err_sticky", ERROR_OUT, 1);
        cyc(8'h01, 1, 0);
        cyc(8'h01, 1, 0);
        RST = 1;
        cyc(0, 0, 0);
        RST = 0;
        chk("midrst_valid", VALID_OUT, 0);
        chk("midrst_err", ERROR_OUT, 0);
        cyc(0, 0, 0);
        chk("midrst_after", VALID_OUT, 0);
        for (int i = 0; i < 4; i++) begin
            cyc(8'h01, 1, 0);
            if (i < 3) chk("midrst_nopulse", VALID_OUT, 0);
        end
        rec("midrst", 'h04, 'h01, 0, 4);
        cyc(0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(mn[i], 1, 0);
        rec("mean_frame", 'h50, 'h20, 3, 4);
`ifdef FIXED_POINT_ABS_PEAK_ACC_MEAN_EN
        chk("mean", MEAN_OUT, 'h14);
`endif
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
